// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: ID-stage bundle between the decode logic and the
// hazard scoreboard. It carries the pipeline controls, the instruction's
// operand/destination fields, and the scoreboard's stall/issue/debug outputs.
interface hazard_scoreboard_unit_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_REGS   = 16,
    parameter int NUM_SRC    = 3,
    parameter int LAT_W      = 3
);
    logic                          freeze;
    logic                          flush;
    logic                          id_valid;
    logic [NUM_SRC-1:0]            has_src;
    logic [NUM_SRC*REG_ADDR_W-1:0] src;
    logic                          wb_en;
    logic [REG_ADDR_W-1:0]         dest;
    logic [LAT_W-1:0]              latency;
    logic                          hazard_detected;
    logic                          issue_fire;
    logic [NUM_REGS-1:0]           busy_mask;
    logic [15:0]                   stall_count;

    modport master (
        output freeze, flush, id_valid, has_src, src, wb_en, dest, latency,
        input  hazard_detected, issue_fire, busy_mask, stall_count
    );

    modport slave (
        input  freeze, flush, id_valid, has_src, src, wb_en, dest, latency,
        output hazard_detected, issue_fire, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register pending-write scoreboard at ID.
// Each architectural register has a countdown of cycles until its in-flight
// result reaches the register file; reads of a pending register (RAW) and
// writes that would land before an older write (WAW) stall IF/ID.
// A saturating 16-bit counter records hazard stall cycles for debug.
// Optional feature macro: HAZARD_FORWARDING_EN -- when defined, sources whose
// pending count is 1..FWD_DIST are treated as forwardable and do not stall.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_REGS   = 16,
    parameter int NUM_SRC    = 3,
    parameter int LAT_W      = 3,
    parameter int FWD_DIST   = 1
) (
    input logic                     clk,
    input logic                     rst,
    hazard_scoreboard_unit_if.slave bus
);

`ifdef HAZARD_FORWARDING_EN
    localparam int SRC_STALL_ABOVE = FWD_DIST;
`else
    // Without forwarding any nonzero count stalls, so FWD_DIST has no effect.
    localparam int SRC_STALL_ABOVE = 0 * FWD_DIST;
`endif
    localparam logic [LAT_W-1:0] SRC_THRESH = LAT_W'(SRC_STALL_ABOVE);

    logic [LAT_W-1:0]    pend_cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    pend_cnt_d [NUM_REGS];
    logic [15:0]         stall_count_q;
    logic [15:0]         stall_count_d;
    logic [NUM_SRC-1:0]  src_hit;
    logic                waw_hit;
    logic                hazard;
    logic                issue;
    logic [NUM_REGS-1:0] busy;

    // Hazard detection: RAW on any read source, WAW when an older write lands later.
    always_comb begin
        src_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_hit[i] = bus.has_src[i] &&
                         (pend_cnt_q[bus.src[i*REG_ADDR_W +: REG_ADDR_W]] > SRC_THRESH);
        end
        waw_hit = bus.wb_en && (pend_cnt_q[bus.dest] > bus.latency);
        hazard  = bus.id_valid && ((|src_hit) || waw_hit);
        issue   = bus.id_valid && !hazard && !bus.freeze && !bus.flush;
    end

    // Countdown update: hold on freeze, otherwise age every entry and load on issue.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_cnt_d[r] = pend_cnt_q[r];
        end
        if (!bus.freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (pend_cnt_q[r] != '0) begin
                    pend_cnt_d[r] = pend_cnt_q[r] - LAT_W'(1);
                end
            end
            if (issue && bus.wb_en && (bus.latency != '0)) begin
                pend_cnt_d[bus.dest] = bus.latency;
            end
        end
    end

    // Stall-cycle counter saturates at all-ones so long runs never wrap to small values.
    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.id_valid && hazard && !bus.flush && !bus.freeze &&
            (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Busy mask is a direct view of which entries are still counting down.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (pend_cnt_q[r] != '0);
        end
    end

    // State registers with synchronous reset dropping all pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_cnt_q[r] <= pend_cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.hazard_detected = hazard;
    assign bus.issue_fire      = issue;
    assign bus.busy_mask       = busy;
    assign bus.stall_count     = stall_count_q;

endmodule
